// File: rtl/fetch_queue_if_pkg.sv
// Shared widths, defaults and helpers for the multi-outstanding fetch stage.
package fetch_queue_if_pkg;

    localparam int unsigned BUS_WIDTH          = 32;
    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned FQ_DEPTH           = 4;
    localparam int unsigned FQ_MAX_OUTSTANDING = 2;
    localparam logic [31:0] FQ_RESET_PC        = 32'hfffffffc;

    // Bits needed to hold a counter that ranges over 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if_if.sv
// ROM request/response bus between the fetch stage (master) and instruction ROM (slave).
interface fetch_queue_if_if
    import fetch_queue_if_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = fetch_queue_if_pkg::BUS_WIDTH,
    parameter int unsigned DATA_WIDTH = fetch_queue_if_pkg::DATA_WIDTH
) ();

    logic                  mem_req;
    logic [BUS_WIDTH-1:0]  mem_addr;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_WIDTH-1:0] rom_rdata;
    logic                  data_ok_resp;

    modport master (
        output mem_req,
        output mem_addr,
        output data_ok_resp,
        input  mem_addr_ok,
        input  mem_data_ok,
        input  rom_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  data_ok_resp,
        output mem_addr_ok,
        output mem_data_ok,
        output rom_rdata
    );

endinterface

// File: rtl/fetch_queue_if_fetch_buffer.sv
// In-order fetch buffer: entry array with head/tail/fill pointers, occupancy and pending counts.
module if_fetch_buffer
    import fetch_queue_if_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH  = fetch_queue_if_pkg::BUS_WIDTH,
    parameter int unsigned          DATA_WIDTH = fetch_queue_if_pkg::DATA_WIDTH,
    parameter int unsigned          DEPTH      = FQ_DEPTH,
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = FQ_RESET_PC,
    localparam int unsigned         PW         = $clog2(DEPTH),
    localparam int unsigned         CW         = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [BUS_WIDTH-1:0]  alloc_pc,
    input  logic                  fill_en,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  commit,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         pending,
    output logic [BUS_WIDTH-1:0]  head_pc,
    output logic [DATA_WIDTH-1:0] head_inst,
    output logic                  head_filled,
    output logic                  fill_at_head
);

    logic [BUS_WIDTH-1:0]  pc_q     [DEPTH];
    logic [DATA_WIDTH-1:0] inst_q   [DEPTH];
    logic                  filled_q [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= RESET_PC;
                inst_q[i]   <= '0;
                filled_q[i] <= 1'b0;
            end
            head    <= '0;
            tail    <= '0;
            fill    <= '0;
            count   <= '0;
            pending <= '0;
        end else if (flush) begin
            // A redirect accepted alongside the flush becomes the sole entry, at index 0.
            head    <= '0;
            fill    <= '0;
            tail    <= alloc ? PW'(1) : '0;
            count   <= alloc ? CW'(1) : '0;
            pending <= alloc ? CW'(1) : '0;
            if (alloc) begin
                pc_q[0]     <= alloc_pc;
                filled_q[0] <= 1'b0;
            end
        end else begin
            if (fill_en) begin
                inst_q[fill]   <= fill_data;
                filled_q[fill] <= 1'b1;
                fill           <= fill + PW'(1);
            end
            if (alloc) begin
                pc_q[tail]     <= alloc_pc;
                filled_q[tail] <= 1'b0;
                tail           <= tail + PW'(1);
            end
            if (commit) begin
                head <= head + PW'(1);
            end
            count   <= count + CW'(alloc) - CW'(commit);
            pending <= pending + CW'(alloc) - CW'(fill_en);
        end
    end

    assign head_pc      = pc_q[head];
    assign head_inst    = inst_q[head];
    assign head_filled  = filled_q[head];
    assign fill_at_head = (fill == head);

endmodule

// File: rtl/fetch_queue_if.sv
// Fetch stage with several ROM requests in flight; discards responses orphaned by cancel.
module fetch_queue_if
    import fetch_queue_if_pkg::*;
#(
    parameter int unsigned          BUS_WIDTH       = fetch_queue_if_pkg::BUS_WIDTH,
    parameter int unsigned          DATA_WIDTH      = fetch_queue_if_pkg::DATA_WIDTH,
    parameter int unsigned          DEPTH           = FQ_DEPTH,
    parameter int unsigned          MAX_OUTSTANDING = FQ_MAX_OUTSTANDING,
    parameter logic [BUS_WIDTH-1:0] RESET_PC        = FQ_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  cancel,
    input  logic                  valid_pre,
    input  logic                  ready_go_pre,
    input  logic [BUS_WIDTH-1:0]  next_pc,
    output logic                  allow_in_if,
    fetch_queue_if_if.master      mem,
    input  logic                  allow_in_id,
    output logic                  valid_if,
    output logic                  ready_go_if,
    output logic [BUS_WIDTH-1:0]  pc_if,
    output logic [DATA_WIDTH-1:0] instruction_if
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned DW = cnt_width(MAX_OUTSTANDING);

    logic [CW-1:0]         count;
    logic [CW-1:0]         pending;
    logic [DW-1:0]         discard_cnt;
    logic [CW:0]           inflight;
    logic [CW:0]           cancel_sum;
    logic [BUS_WIDTH-1:0]  head_pc;
    logic [DATA_WIDTH-1:0] head_inst;
    logic                  head_filled;
    logic                  fill_at_head;
    logic                  pipe_valid;
    logic                  slot_ok;
    logic                  req_ok;
    logic                  live_resp;
    logic                  bypass;
    logic                  fill_en;
    logic                  commit;

    always_comb begin
        pipe_valid = valid_pre && ready_go_pre;
        inflight   = {1'b0, pending} + (CW + 1)'(discard_cnt);
        slot_ok    = (count < CW'(DEPTH)) && (inflight < (CW + 1)'(MAX_OUTSTANDING));
        allow_in_if      = slot_ok && mem.mem_addr_ok;
        mem.mem_req      = pipe_valid && slot_ok;
        mem.mem_addr     = next_pc;
        mem.data_ok_resp = 1'b1;
        req_ok     = pipe_valid && allow_in_if;

        live_resp  = mem.mem_data_ok && (discard_cnt == '0);
        bypass     = live_resp && (count != '0) && fill_at_head && (pending != '0);
        fill_en    = live_resp && !cancel;

        valid_if       = (count != '0);
        ready_go_if    = (head_filled || bypass) && !hold && valid_if;
        instruction_if = bypass ? mem.rom_rdata : head_inst;
        pc_if          = head_pc;
        commit         = ready_go_if && allow_in_id && !cancel;

        // Every old response still due (pending + already discarding) is dropped; one arriving now is consumed.
        cancel_sum = (CW + 1)'(discard_cnt) + {1'b0, pending} - (CW + 1)'(mem.mem_data_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (cancel) begin
            discard_cnt <= DW'(cancel_sum);
        end else if (mem.mem_data_ok && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - DW'(1);
        end
    end

    if_fetch_buffer #(
        .BUS_WIDTH  (BUS_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .flush        (cancel),
        .alloc        (req_ok),
        .alloc_pc     (next_pc),
        .fill_en      (fill_en),
        .fill_data    (mem.rom_rdata),
        .commit       (commit),
        .count        (count),
        .pending      (pending),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .head_filled  (head_filled),
        .fill_at_head (fill_at_head)
    );

endmodule

// File: tb/tb_fetch_queue_if.sv
// Randomized directed-phase bench for fetch_queue_if against a queue-level reference model.
module tb_fetch_queue_if;

    localparam int unsigned BW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 3;
    localparam logic [31:0] RPC   = 32'hfffffffc;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          cancel;
    logic          valid_pre;
    logic          ready_go_pre;
    logic [BW-1:0] next_pc;
    logic          allow_in_if;
    logic          allow_in_id;
    logic          valid_if;
    logic          ready_go_if;
    logic [BW-1:0] pc_if;
    logic [DW-1:0] instruction_if;

    fetch_queue_if_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) mem_bus ();

    fetch_queue_if #(
        .BUS_WIDTH       (BW),
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .cancel         (cancel),
        .valid_pre      (valid_pre),
        .ready_go_pre   (ready_go_pre),
        .next_pc        (next_pc),
        .allow_in_if    (allow_in_if),
        .mem            (mem_bus),
        .allow_in_id    (allow_in_id),
        .valid_if       (valid_if),
        .ready_go_if    (ready_go_if),
        .pc_if          (pc_if),
        .instruction_if (instruction_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    ent_t        q[$];
    logic [31:0] rom_q[$];
    int          disc;
    bit          pc_known;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;

    int p_pv, p_rg, p_aok, p_data, p_id, p_hold, p_cancel;
    bit rst_req;

    function automatic bit chance(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic logic [31:0] romdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int  cnt, pend, fu;
        bit  slot, e_allow, e_req, req_ok, fresh, e_valid, e_rg, commit;
        logic [31:0] e_inst;

        @(negedge clk);
        rst          = rst_req;
        valid_pre    = chance(p_pv);
        ready_go_pre = chance(p_rg);
        next_pc      = $urandom & 32'hfffffffc;
        hold         = chance(p_hold);
        cancel       = chance(p_cancel);
        allow_in_id  = chance(p_id);
        mem_bus.mem_addr_ok = chance(p_aok);
        mem_bus.mem_data_ok = (rom_q.size() > 0) && chance(p_data);
        mem_bus.rom_rdata   = mem_bus.mem_data_ok ? romdata(rom_q[0]) : $urandom;
        #1;

        cnt  = q.size();
        pend = 0;
        fu   = -1;
        foreach (q[i]) if (!q[i].filled) begin
            pend++;
            if (fu < 0) fu = i;
        end
        slot    = (cnt < DEPTH) && (pend + disc < MAXO);
        e_allow = slot && mem_bus.mem_addr_ok;
        e_req   = valid_pre && ready_go_pre && slot;
        req_ok  = valid_pre && ready_go_pre && e_allow;
        // A live response always targets the oldest unfilled entry; it bypasses only if that is the head.
        fresh   = mem_bus.mem_data_ok && (disc == 0) && (cnt > 0) && !q[0].filled;
        e_valid = (cnt > 0);
        e_rg    = e_valid && (q[0].filled || fresh) && !hold;
        e_inst  = fresh ? mem_bus.rom_rdata : (cnt > 0 ? q[0].inst : 32'h0);
        commit  = e_rg && allow_in_id && !cancel;

        if (!rst) begin
            chk("allow_in_if", allow_in_if, e_allow);
            chk("mem_req", mem_bus.mem_req, e_req);
            chk("mem_addr", mem_bus.mem_addr, next_pc);
            chk("data_ok_resp", mem_bus.data_ok_resp, 1'b1);
            chk("valid_if", valid_if, e_valid);
            chk("ready_go_if", ready_go_if, e_rg);
            if (e_valid) begin
                chk("pc_if", pc_if, q[0].pc);
                if (e_rg) chk("instruction_if", instruction_if, e_inst);
            end else if (pc_known) begin
                chk("pc_if_reset", pc_if, RPC);
            end
        end

        @(posedge clk);
        if (rst) begin
            q.delete();
            rom_q.delete();
            disc     = 0;
            pc_known = 1'b1;
        end else begin
            if (mem_bus.mem_data_ok) void'(rom_q.pop_front());
            if (req_ok) rom_q.push_back(next_pc);
            if (cancel) begin
                disc = disc + pend - (mem_bus.mem_data_ok ? 1 : 0);
                q.delete();
            end else begin
                if (mem_bus.mem_data_ok) begin
                    if (disc > 0) disc--;
                    else if (fu >= 0) begin
                        q[fu].inst   = mem_bus.rom_rdata;
                        q[fu].filled = 1'b1;
                    end
                end
                if (commit) void'(q.pop_front());
            end
            if (req_ok) begin
                q.push_back('{pc: next_pc, inst: 32'h0, filled: 1'b0});
                pc_known = 1'b0;
            end
        end
    endtask

    task automatic knobs(input int pv, rg, aok, data, id, hd, cn);
        p_pv = pv; p_rg = rg; p_aok = aok; p_data = data;
        p_id = id; p_hold = hd; p_cancel = cn;
    endtask

    initial begin
        disc     = 0;
        pc_known = 1'b0;
        rst_req  = 1'b1;
        knobs(0, 0, 100, 0, 0, 0, 0);
        repeat (2) step();
        rst_req = 1'b0;

        // idle after reset: empty, head PC is the reset PC
        repeat (3) step();

        // streaming: every cycle issues, responds and retires
        knobs(100, 100, 100, 100, 100, 0, 0);
        repeat (12) step();

        // hold stalls retirement while the buffer fills
        knobs(100, 100, 100, 100, 100, 100, 0);
        repeat (8) step();
        knobs(0, 0, 100, 100, 100, 0, 0);
        repeat (8) step();

        // full: ID refuses, buffer and outstanding limits both bind
        knobs(100, 100, 100, 100, 0, 0, 0);
        repeat (10) step();
        knobs(100, 100, 100, 100, 50, 0, 0);
        repeat (10) step();

        // cancel-heavy traffic with slow responses
        knobs(90, 90, 80, 40, 70, 10, 25);
        repeat (80) step();

        // general random traffic
        knobs(60, 80, 70, 50, 60, 20, 8);
        repeat (300) step();

        // reset in the middle of a full, stalled stream
        knobs(100, 100, 100, 100, 0, 0, 0);
        repeat (6) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        knobs(0, 0, 100, 0, 0, 0, 0);
        step();

        knobs(70, 80, 70, 60, 60, 15, 10);
        repeat (300) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
